i2c_bus_conditioner: RTL and testbench

Front-end stage directly upstream of the I2C slave transceiver. It synchronises and glitch-filters the raw SCL/SDA pad inputs, then presents clean levels to the transceiver. It also provides one-cycle SCL rise/fall strobes, START/STOP condition strobes, a bus-busy flag and an SCL-low timeout that frees a hung bus. All logic runs in the system clock domain.

---
 rtl/i2c_bus_conditioner_if.sv | 21 ++
 rtl/i2c_bus_conditioner.sv | 71 +++++++
 tb/tb_i2c_bus_conditioner.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/i2c_bus_conditioner_if.sv
// i2c_bus_conditioner_if: raw pad inputs and conditioned bus outputs of the I2C front-end
interface i2c_bus_conditioner_if;
  logic scl_i;
  logic sda_i;
  logic scl_o;
  logic sda_o;
  logic scl_rise_o;
  logic scl_fall_o;
  logic start_o;
  logic stop_o;
  logic bus_busy_o;
  logic timeout_o;
  modport slave (
    input  scl_i, sda_i,
    output scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, bus_busy_o, timeout_o
  );
  modport master (
    output scl_i, sda_i,
    input  scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, bus_busy_o, timeout_o
  );
endinterface

// File: rtl/i2c_bus_conditioner.sv
// i2c_bus_conditioner: sync + glitch-filter SCL/SDA, edge/START/STOP strobes, busy flag and SCL-low timeout
module i2c_bus_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                  clk_i,
  input logic                  reset_i,
  i2c_bus_conditioner_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  typedef enum logic {IDLE, BUSY} state_e;
  state_e                       state_q, state_d;
  logic [1:0][SYNC_STAGES-1:0]  sync_q;
  logic [1:0][3:0]              flt_cnt_q, flt_cnt_d;
  logic [1:0]                   line_q, line_d;
  logic [TW-1:0]                to_cnt_q, to_cnt_d;
  logic                         scl_rise_q, scl_fall_q, start_q, stop_q, timeout_q;
  logic                         scl_hold, start_c, stop_c, counting, tmo_c;
  // index 0 is SCL, index 1 is SDA throughout
  always_comb begin
    line_d    = line_q;
    flt_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      line_d[i]    = (sync_q[i][SYNC_STAGES-1] != line_q[i] && flt_cnt_q[i] == 4'(FILTER_LEN-1))
                     ? sync_q[i][SYNC_STAGES-1] : line_q[i];
      flt_cnt_d[i] = (sync_q[i][SYNC_STAGES-1] == line_q[i] || flt_cnt_q[i] == 4'(FILTER_LEN-1))
                     ? 4'd0 : flt_cnt_q[i] + 4'd1;
    end
    scl_hold = line_q[0] & line_d[0];
    start_c  = scl_hold & line_q[1] & ~line_d[1];
    stop_c   = scl_hold & ~line_q[1] & line_d[1];
    counting = (state_q == BUSY) & ~line_q[0];
    tmo_c    = counting & ~start_c & ~stop_c & (to_cnt_q == TW'(TIMEOUT_CYCLES-1));
    state_d  = stop_c ? IDLE : start_c ? BUSY : tmo_c ? IDLE : state_q;
    to_cnt_d = (counting & ~start_c & ~tmo_c) ? to_cnt_q + TW'(1) : '0;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      sync_q     <= '1;
      line_q     <= '1;
      flt_cnt_q  <= '0;
      to_cnt_q   <= '0;
      state_q    <= IDLE;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1][SYNC_STAGES-2:0], bus.sda_i, sync_q[0][SYNC_STAGES-2:0], bus.scl_i};
      line_q     <= line_d;
      flt_cnt_q  <= flt_cnt_d;
      to_cnt_q   <= to_cnt_d;
      state_q    <= state_d;
      scl_rise_q <= ~line_q[0] & line_d[0];
      scl_fall_q <= line_q[0] & ~line_d[0];
      start_q    <= start_c;
      stop_q     <= stop_c;
      timeout_q  <= tmo_c;
    end
  end
  assign bus.scl_o      = line_q[0];
  assign bus.sda_o      = line_q[1];
  assign bus.scl_rise_o = scl_rise_q;
  assign bus.scl_fall_o = scl_fall_q;
  assign bus.start_o    = start_q;
  assign bus.stop_o     = stop_q;
  assign bus.bus_busy_o = (state_q == BUSY);
  assign bus.timeout_o  = timeout_q;
endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// tb_i2c_bus_conditioner: scoreboard bench; expected strobes are queued at stimulus time and matched as they appear
module tb_i2c_bus_conditioner;
  localparam int LAT = 6;
  localparam int TMO = 1024;
  localparam int EV_START = 0, EV_STOP = 1, EV_RISE = 2, EV_FALL = 3, EV_TMO = 4;
  typedef struct { int kind; int at; } ev_t;
  logic clk_i = 1'b0;
  logic reset_i = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  sb[$];
  ev_t  e;
  logic [4:0] ev;
  i2c_bus_conditioner_if bus();
  i2c_bus_conditioner dut (.clk_i(clk_i), .reset_i(reset_i), .bus(bus));
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic wt(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  task automatic push(input int kind, input int at);
    ev_t x;
    x.kind = kind;
    x.at   = at;
    sb.push_back(x);
  endtask
  always @(negedge clk_i) if (reset_i) begin
    ev = {bus.timeout_o, bus.scl_fall_o, bus.scl_rise_o, bus.stop_o, bus.start_o};
    for (int b = 0; b < 5; b++) if (ev[b]) begin
      if (sb.size() == 0) chk("unexpected_event", b, -1);
      else begin
        e = sb.pop_front();
        chk("event_kind", b, e.kind);
        chk("event_cycle", cyc, e.at);
      end
    end
  end
  initial begin
    bus.scl_i = 1'b1;
    bus.sda_i = 1'b1;
    reset_i   = 1'b0;
    wt(3);
    chk("rst_scl", bus.scl_o, 1);
    chk("rst_sda", bus.sda_o, 1);
    chk("rst_busy", bus.bus_busy_o, 0);
    chk("rst_strobes", {bus.timeout_o, bus.scl_fall_o, bus.scl_rise_o, bus.stop_o, bus.start_o}, 0);
    reset_i = 1'b1;
    wt(4);
    chk("rel_scl", bus.scl_o, 1);
    chk("rel_sda", bus.sda_o, 1);
    chk("rel_busy", bus.bus_busy_o, 0);
    // plain START then STOP
    bus.sda_i = 1'b0; push(EV_START, cyc + LAT);
    wt(LAT - 1);
    chk("pre_start_sda", bus.sda_o, 1);
    wt(1);
    chk("start_sda", bus.sda_o, 0);
    chk("start_busy", bus.bus_busy_o, 1);
    wt(6);
    bus.sda_i = 1'b1; push(EV_STOP, cyc + LAT);
    wt(10);
    chk("stop_busy", bus.bus_busy_o, 0);
    // 3-clock glitch is swallowed, 4-clock pulse passes
    bus.sda_i = 1'b0;
    wt(3);
    bus.sda_i = 1'b1;
    wt(10);
    chk("glitch_sda", bus.sda_o, 1);
    chk("glitch_busy", bus.bus_busy_o, 0);
    bus.sda_i = 1'b0; push(EV_START, cyc + LAT); push(EV_STOP, cyc + LAT + 4);
    wt(4);
    bus.sda_i = 1'b1;
    wt(12);
    chk("pulse_busy", bus.bus_busy_o, 0);
    // START, 9 SCL periods with SDA moving only while SCL is low
    bus.sda_i = 1'b0; push(EV_START, cyc + LAT);
    wt(10);
    for (int p = 0; p < 9; p++) begin
      bus.scl_i = 1'b0; push(EV_FALL, cyc + LAT);
      wt(5);
      bus.sda_i = ~bus.sda_i;
      wt(5);
      bus.scl_i = 1'b1; push(EV_RISE, cyc + LAT);
      wt(10);
    end
    chk("xfer_busy", bus.bus_busy_o, 1);
    chk("xfer_sda", bus.sda_o, 1);
    bus.sda_i = 1'b0; push(EV_START, cyc + LAT);
    wt(10);
    chk("rstart_busy", bus.bus_busy_o, 1);
    bus.sda_i = 1'b1; push(EV_STOP, cyc + LAT);
    wt(10);
    chk("xfer_end_busy", bus.bus_busy_o, 0);
    // simultaneous SCL/SDA change is data, not a condition
    bus.scl_i = 1'b0; bus.sda_i = 1'b0; push(EV_FALL, cyc + LAT);
    wt(10);
    chk("simul_busy", bus.bus_busy_o, 0);
    chk("simul_sda", bus.sda_o, 0);
    bus.scl_i = 1'b1; bus.sda_i = 1'b1; push(EV_RISE, cyc + LAT);
    wt(10);
    chk("simul_back_busy", bus.bus_busy_o, 0);
    // SCL-low timeout, and no second timeout without a new START
    bus.sda_i = 1'b0; push(EV_START, cyc + LAT);
    wt(10);
    bus.scl_i = 1'b0; push(EV_FALL, cyc + LAT); push(EV_TMO, cyc + LAT + TMO);
    wt(LAT + TMO - 1);
    chk("pre_tmo_busy", bus.bus_busy_o, 1);
    wt(1);
    chk("tmo_busy", bus.bus_busy_o, 0);
    wt(TMO + 50);
    chk("post_tmo_busy", bus.bus_busy_o, 0);
    bus.scl_i = 1'b1; push(EV_RISE, cyc + LAT);
    wt(10);
    bus.sda_i = 1'b1; push(EV_STOP, cyc + LAT);
    wt(10);
    // reset while the timeout counter is running
    bus.sda_i = 1'b0; push(EV_START, cyc + LAT);
    wt(10);
    bus.scl_i = 1'b0; push(EV_FALL, cyc + LAT);
    wt(500);
    reset_i = 1'b0;
    wt(2);
    chk("midrst_busy", bus.bus_busy_o, 0);
    chk("midrst_scl", bus.scl_o, 1);
    chk("midrst_sda", bus.sda_o, 1);
    reset_i = 1'b1; push(EV_FALL, cyc + LAT);
    wt(TMO + 100);
    chk("midrst_after_busy", bus.bus_busy_o, 0);
    bus.scl_i = 1'b1; bus.sda_i = 1'b1; push(EV_RISE, cyc + LAT);
    wt(12);
    chk("queue_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
